// File: rtl/gbdt_pkg.sv
// Shared types and helpers for the GBDT classifier back end.
// Used by the argmax accumulator and its lane reduction tree.
package gbdt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } argmax_state_t;

    localparam int SCORE_MAX_W = 64;

    // Callers pass scores already sign- or zero-extended to 64 bits
    function automatic logic score_gt(
        input logic [SCORE_MAX_W-1:0] a,
        input logic [SCORE_MAX_W-1:0] b,
        input logic                   signed_mode
    );
        if (signed_mode)
            return $signed(a) > $signed(b);
        return a > b;
    endfunction

    function automatic int calc_rounds(input int num_classes, input int lanes);
        return (num_classes + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/gbdt_argmax_tree.sv
// Combinational top-1 / top-2 reduction over one beat of lane scores.
// Balanced tournament tree; on equal scores the lower lane wins.
module gbdt_argmax_tree
    import gbdt_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int LANES  = 8,
    parameter  int SIGNED = 0,
    localparam int LANE_W = $clog2(LANES)
) (
    input  logic [LANES*DATA_W-1:0] scores,
    input  logic [LANES-1:0]        mask,
    output logic                    top1_valid,
    output logic [DATA_W-1:0]       top1,
    output logic [LANE_W-1:0]       top1_lane,
    output logic                    top2_valid,
    output logic [DATA_W-1:0]       top2
);

    typedef struct packed {
        logic              v;
        logic [DATA_W-1:0] t1;
        logic [LANE_W-1:0] lane;
        logic              h2;
        logic [DATA_W-1:0] t2;
    } node_t;

    node_t node [1:2*LANES-1];

    function automatic logic [SCORE_MAX_W-1:0] ext(input logic [DATA_W-1:0] v);
        if (SIGNED != 0)
            return SCORE_MAX_W'($signed(v));
        return SCORE_MAX_W'(v);
    endfunction

    function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return score_gt(ext(a), ext(b), 1'(SIGNED != 0));
    endfunction

    // a always covers the lower lanes, so it keeps ties
    function automatic node_t merge(input node_t a, input node_t b);
        node_t n;
        node_t w;
        node_t l;
        n = a;
        if (!a.v) begin
            n = b;
        end else if (b.v) begin
            w = gt(b.t1, a.t1) ? b : a;
            l = gt(b.t1, a.t1) ? a : b;
            n.v    = 1'b1;
            n.t1   = w.t1;
            n.lane = w.lane;
            n.h2   = 1'b1;
            n.t2   = (w.h2 && gt(w.t2, l.t1)) ? w.t2 : l.t1;
        end
        return n;
    endfunction

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            node[LANES+i].v    = mask[i];
            node[LANES+i].t1   = scores[i*DATA_W +: DATA_W];
            node[LANES+i].lane = LANE_W'(i);
            node[LANES+i].h2   = 1'b0;
            node[LANES+i].t2   = '0;
        end
        for (int i = LANES - 1; i >= 1; i--)
            node[i] = merge(node[2*i], node[2*i+1]);
    end

    assign top1_valid = node[1].v;
    assign top1       = node[1].t1;
    assign top1_lane  = node[1].lane;
    assign top2_valid = node[1].h2;
    assign top2       = node[1].t2;

endmodule

// File: rtl/gbdt_argmax_acc.sv
// Multi-round argmax accumulator: running max, its class and the runner-up
// over ROUNDS beats of LANES scores, with a one-cycle done pulse.
module gbdt_argmax_acc
    import gbdt_pkg::*;
#(
    parameter  int DATA_W      = 32,
    parameter  int LANES       = 8,
    parameter  int NUM_CLASSES = 32,
    parameter  int SIGNED      = 0,
    localparam int CLASS_W     = $clog2(NUM_CLASSES)
) (
    input  logic                    gbdt_clk,
    input  logic                    gbdt_rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_scores,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_W-1:0]       max_score,
    output logic [CLASS_W-1:0]      max_class,
    output logic [DATA_W-1:0]       second_score
);

    localparam int ROUNDS = calc_rounds(NUM_CLASSES, LANES);
    localparam int RND_W  = $clog2(ROUNDS + 1);
    localparam int LANE_W = $clog2(LANES);

    typedef struct packed {
        logic              first;
        logic              last;
        logic [RND_W-1:0]  rnd;
        logic [DATA_W-1:0] t1;
        logic [LANE_W-1:0] lane;
        logic              h2;
        logic [DATA_W-1:0] t2;
    } s1_t;

    argmax_state_t state, state_nxt;

    logic [RND_W-1:0]   rnd;
    logic               accept;
    logic               last_beat;
    logic [LANES-1:0]   lane_mask;
    logic               t_v;
    logic [DATA_W-1:0]  t_1;
    logic [LANE_W-1:0]  t_lane;
    logic               t_h2;
    logic [DATA_W-1:0]  t_2;
    logic               s1_valid;
    s1_t                s1_q;
    logic [DATA_W-1:0]  r_max, r_sec, m_max, m_sec, lose;
    logic [CLASS_W-1:0] r_cls, m_cls, cls_new;

    function automatic logic [SCORE_MAX_W-1:0] ext(input logic [DATA_W-1:0] v);
        if (SIGNED != 0)
            return SCORE_MAX_W'($signed(v));
        return SCORE_MAX_W'(v);
    endfunction

    function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return score_gt(ext(a), ext(b), 1'(SIGNED != 0));
    endfunction

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE:  if (start) state_nxt = ACCUM;
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && last_beat) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!s1_valid) state_nxt = DONE;
            end
            DONE:  if (start) state_nxt = ACCUM;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    assign accept    = in_valid && in_ready && !abort;
    assign last_beat = (rnd == RND_W'(ROUNDS - 1));

    // Padding lanes past the last class never take part
    always_comb begin
        for (int i = 0; i < LANES; i++)
            lane_mask[i] = (int'(rnd) * LANES + i) < NUM_CLASSES;
    end

    gbdt_argmax_tree #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .SIGNED (SIGNED)
    ) u_tree (
        .scores     (in_scores),
        .mask       (lane_mask),
        .top1_valid (t_v),
        .top1       (t_1),
        .top1_lane  (t_lane),
        .top2_valid (t_h2),
        .top2       (t_2)
    );

    assign cls_new = CLASS_W'(s1_q.rnd) * CLASS_W'(LANES) + CLASS_W'(s1_q.lane);

    // Earlier rounds hold lower classes, so keeping the old max on ties
    // gives the lower class index.
    always_comb begin
        m_max = r_max;
        m_cls = r_cls;
        m_sec = r_sec;
        lose  = s1_q.t1;
        if (s1_q.first) begin
            m_max = s1_q.t1;
            m_cls = cls_new;
            m_sec = s1_q.t2;
        end else begin
            if (gt(s1_q.t1, r_max)) begin
                m_max = s1_q.t1;
                m_cls = cls_new;
                lose  = r_max;
            end
            if (gt(lose, m_sec)) m_sec = lose;
            if (s1_q.h2 && gt(s1_q.t2, m_sec)) m_sec = s1_q.t2;
        end
    end

    always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
        if (!gbdt_rst_n) begin
            state    <= IDLE;
            rnd      <= '0;
            done     <= 1'b0;
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else begin
            state    <= state_nxt;
            done     <= (state == DRAIN) && (state_nxt == DONE);
            s1_valid <= accept;
            if (accept)
                s1_q <= '{first: (rnd == '0), last: last_beat, rnd: rnd,
                          t1: t_1, lane: t_lane, h2: t_h2 & t_v, t2: t_2};
            if (abort)
                rnd <= '0;
            else if (accept)
                rnd <= last_beat ? '0 : rnd + 1'b1;
            else if (state_nxt == ACCUM && state != ACCUM)
                rnd <= '0;
        end
    end

    always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
        if (!gbdt_rst_n) begin
            r_max        <= '0;
            r_cls        <= '0;
            r_sec        <= '0;
            max_score    <= '0;
            max_class    <= '0;
            second_score <= '0;
        end else if (s1_valid && !abort) begin
            r_max <= m_max;
            r_cls <= m_cls;
            r_sec <= m_sec;
            if (s1_q.last) begin
                max_score    <= m_max;
                max_class    <= m_cls;
                second_score <= m_sec;
            end
        end
    end

endmodule

// File: tb/tb_gbdt_argmax_acc.sv
// Directed bench for gbdt_argmax_acc: unsigned, signed and
// padded-class instances driven through one shared stimulus path.
module tb_gbdt_argmax_acc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic in_valid = 1'b0;
    logic [255:0] scores = '0;
    int sel = 0;
    logic [31:0] sc [32];
    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] st, ab, iv, rdy, bsy, dn;
    logic [2:0][31:0] ms, ss;
    logic [2:0][4:0] mc;
    logic o_rdy, o_bsy, o_dn;
    logic [31:0] o_ms, o_ss;
    logic [4:0] o_mc;

    always #5 clk = ~clk;

    assign st = start ? 3'(1 << sel) : 3'b0;
    assign ab = abort ? 3'(1 << sel) : 3'b0;
    assign iv = in_valid ? 3'(1 << sel) : 3'b0;
    assign o_rdy = rdy[sel];
    assign o_bsy = bsy[sel];
    assign o_dn = dn[sel];
    assign o_ms = ms[sel];
    assign o_mc = mc[sel];
    assign o_ss = ss[sel];

    gbdt_argmax_acc #(.SIGNED(0)) u0 (
        .gbdt_clk(clk), .gbdt_rst_n(rst_n), .start(st[0]), .abort(ab[0]),
        .in_valid(iv[0]), .in_ready(rdy[0]), .in_scores(scores), .busy(bsy[0]),
        .done(dn[0]), .max_score(ms[0]), .max_class(mc[0]), .second_score(ss[0]));

    gbdt_argmax_acc #(.SIGNED(1)) u1 (
        .gbdt_clk(clk), .gbdt_rst_n(rst_n), .start(st[1]), .abort(ab[1]),
        .in_valid(iv[1]), .in_ready(rdy[1]), .in_scores(scores), .busy(bsy[1]),
        .done(dn[1]), .max_score(ms[1]), .max_class(mc[1]), .second_score(ss[1]));

    gbdt_argmax_acc #(.NUM_CLASSES(20)) u2 (
        .gbdt_clk(clk), .gbdt_rst_n(rst_n), .start(st[2]), .abort(ab[2]),
        .in_valid(iv[2]), .in_ready(rdy[2]), .in_scores(scores), .busy(bsy[2]),
        .done(dn[2]), .max_score(ms[2]), .max_class(mc[2]), .second_score(ss[2]));

    function automatic logic [255:0] pack(input int r);
        logic [255:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            p[i*32 +: 32] = sc[r*8+i];
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int nb, input bit gap);
        int w;
        for (int r = 0; r < nb; r++) begin
            if (gap && r > 0) @(negedge clk);
            scores = pack(r);
            in_valid = 1'b1;
            w = 0;
            while (!o_rdy && w < 10) begin
                @(negedge clk);
                w++;
            end
            chk("ready_wait", 32'(o_rdy), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag);
        chk({tag, "_done_t0"}, 32'(o_dn), 32'd0);
        @(negedge clk);
        chk({tag, "_done_t1"}, 32'(o_dn), 32'd0);
        @(negedge clk);
        chk({tag, "_done_t2"}, 32'(o_dn), 32'd1);
        chk({tag, "_busy_done"}, 32'(o_bsy), 32'd0);
    endtask

    task automatic check_res(input string tag, input logic [31:0] e_ms,
                             input logic [31:0] e_mc, input logic [31:0] e_ss);
        chk({tag, "_max_score"}, o_ms, e_ms);
        chk({tag, "_max_class"}, 32'(o_mc), e_mc);
        chk({tag, "_second"}, o_ss, e_ss);
    endtask

    task automatic load_t1();
        for (int i = 0; i < 32; i++) sc[i] = 32'(i * 3);
        sc[19] = 32'h500;
    endtask

    task automatic load_t3();
        for (int i = 0; i < 32; i++) sc[i] = 32'h9000_0000 + 32'(i);
        sc[0] = 32'h8000_0000;
        sc[5] = 32'hFFFF_FFFE;
        sc[10] = 32'hFFFF_FFFF;
    endtask

    initial begin
        int pulses;
        sel = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(o_rdy), 32'd0);
        chk("rst_busy", 32'(o_bsy), 32'd0);
        chk("rst_done", 32'(o_dn), 32'd0);
        check_res("rst", 32'd0, 32'd0, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        load_t1();
        start_run();
        chk("t1_ready", 32'(o_rdy), 32'd1);
        chk("t1_busy", 32'(o_bsy), 32'd1);
        feed(4, 1'b0);
        wait_done("t1");
        check_res("t1", 32'h500, 32'd19, 32'h5D);

        for (int i = 0; i < 32; i++) sc[i] = 32'd0;
        sc[3] = 32'h7FFF_FFFF;
        sc[27] = 32'h7FFF_FFFF;
        start_run();
        chk("t2_done_pulse", 32'(o_dn), 32'd0);
        chk("t2_ready", 32'(o_rdy), 32'd1);
        chk("t2_hold_class", 32'(o_mc), 32'd19);
        feed(4, 1'b0);
        wait_done("t2");
        check_res("t2", 32'h7FFF_FFFF, 32'd3, 32'h7FFF_FFFF);

        sel = 1;
        load_t3();
        start_run();
        feed(4, 1'b0);
        wait_done("t3s");
        check_res("t3s", 32'hFFFF_FFFF, 32'd10, 32'hFFFF_FFFE);

        for (int i = 0; i < 32; i++) sc[i] = 32'h8000_0000 + 32'(i);
        sc[4] = 32'd5;
        sc[20] = 32'hFFFF_FFFF;
        start_run();
        feed(4, 1'b0);
        wait_done("t3p");
        check_res("t3p", 32'd5, 32'd4, 32'hFFFF_FFFF);

        sel = 0;
        load_t3();
        start_run();
        feed(4, 1'b0);
        wait_done("t3u");
        check_res("t3u", 32'hFFFF_FFFF, 32'd10, 32'hFFFF_FFFE);

        sel = 2;
        for (int i = 0; i < 32; i++) sc[i] = (i < 20) ? 32'(i % 8) : 32'hFFFF_FFFF;
        sc[12] = 32'h10;
        start_run();
        feed(3, 1'b0);
        wait_done("t4");
        check_res("t4", 32'h10, 32'd12, 32'd7);

        sel = 0;
        for (int i = 0; i < 32; i++) sc[i] = 32'(i);
        sc[30] = 32'h1234;
        start_run();
        feed(2, 1'b1);
        chk("t5_hold_mid", 32'(o_mc), 32'd10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_abort_busy", 32'(o_bsy), 32'd0);
        chk("t5_abort_ready", 32'(o_rdy), 32'd0);
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (o_dn) pulses++;
        end
        chk("t5_no_done", 32'(pulses), 32'd0);
        check_res("t5_kept", 32'hFFFF_FFFF, 32'd10, 32'hFFFF_FFFE);
        start_run();
        chk("t5_hold_accum", 32'(o_mc), 32'd10);
        feed(4, 1'b1);
        wait_done("t5");
        check_res("t5", 32'h1234, 32'd30, 32'h1F);

        load_t1();
        start_run();
        feed(4, 1'b0);
        chk("t6_in_drain", 32'(o_bsy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(o_bsy), 32'd0);
        chk("t6_rst_done", 32'(o_dn), 32'd0);
        chk("t6_rst_ready", 32'(o_rdy), 32'd0);
        check_res("t6_rst", 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_run();
        feed(4, 1'b0);
        wait_done("t6");
        check_res("t6", 32'h500, 32'd19, 32'h5D);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gbdt_argmax_acc.md
# gbdt_argmax_acc

Parametrised multi-round argmax accumulator for the GBDT classifier back end. It consumes per-class scores from the tree-sum stage as a stream of LANES-wide beats and tracks the running maximum score, its global class index and the runner-up score across all rounds of one inference. It then emits a one-cycle completion pulse with the result held stable. It sits between the score accumulator and the result/CSR interface, and generalises the fixed 8-lane, 4-round, unsigned max block.

## Interface
Parameters:
- DATA_W, 32, score width in bits
- LANES, 8, scores per beat (≥2, power of two)
- NUM_CLASSES, 32, total classes per inference (≥2)
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned compare
- CLASS_W, $clog2(NUM_CLASSES), class index width (derived, not overridden)

Ports:
- gbdt_clk  in  1  clock
- gbdt_rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a new inference; sampled only in IDLE or DONE
- abort  in  1  synchronous flush to IDLE; results are not updated
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_scores  in  LANES×DATA_W  lane i holds the score of class round×LANES+i
- busy  out  1  high in ACCUM and DRAIN
- done  out  1  one-cycle pulse when results are final
- max_score  out  DATA_W  winning score
- max_class  out  CLASS_W  winning class index
- second_score  out  DATA_W  best score among all other classes

## Operation
- ROUNDS = ceil(NUM_CLASSES/LANES). Round counter width is $clog2(ROUNDS+1).
- FSM states: IDLE, ACCUM, DRAIN, DONE.
  - IDLE→ACCUM on start.
  - ACCUM→DRAIN on acceptance of beat ROUNDS-1.
  - DRAIN→DONE when the pipeline is empty.
  - DONE→ACCUM on start; otherwise DONE holds.
  - abort from any state → IDLE. abort takes priority over start and over beat acceptance.
- in_ready = (state==ACCUM). No beat is accepted in IDLE, DRAIN or DONE.
- Lanes whose global index is ≥ NUM_CLASSES in the final round are masked and never win, even if their score is the maximum.
- Stage 1 (registered): lane-level top-1 (value, lane) and top-2 value over the unmasked lanes of the accepted beat.
- Stage 2 (registered): merge into the running state.
  - The first beat of an inference initialises the running state directly. There is no sentinel value.
  - Later beats: a new winner requires a strictly greater score. On ties the lower class index wins.
  - Runner-up = max of the old runner-up, the beat's top-2, and the losing top-1.
- Global class = round×LANES + lane, computed at CLASS_W bits. No overflow is possible because the masked lanes cannot win.
- Compare is signed when SIGNED=1, unsigned otherwise. Both stages use the same compare function.
- Outputs update only when stage 2 retires the final beat. They hold through DONE, the next ACCUM and IDLE until the next inference completes.
- abort clears the pipeline valids and the round counter. Outputs keep their last completed values.
- start in ACCUM or DRAIN is ignored.

## Timing
- Reset values: in_ready=0, busy=0, done=0, max_score=0, max_class=0, second_score=0, state=IDLE, all pipeline valids 0.
- start sampled at edge e → in_ready=1 from cycle e+1.
- Final beat accepted at edge t → stage 1 at edge t, stage 2 and outputs at edge t+1, done=1 for cycle t+2 only. Latency from last acceptance to done is 2 cycles.
- A back-to-back stream gives one beat per cycle with no bubbles. in_valid may drop at any time and ACCUM waits.
- A start in the DONE cycle is honoured: done is still pulsed in that cycle, and in_ready=1 from the next cycle.
- Reset asserted mid-inference returns all outputs to reset values immediately (asynchronous).

## Structure
- Shared package gbdt_pkg holds:
  - the state enum argmax_state_t {IDLE, ACCUM, DRAIN, DONE}
  - function score_gt(a, b, signed_mode)
  - the ROUNDS computation as a function
- Sub-module gbdt_argmax_tree: combinational top-1/top-2 reduction over LANES with a lane mask input, balanced tournament tree. It is instantiated once, in stage 1.

## Test plan
- Defaults, unsigned; 4 beats with class 19 = 0x500 and all others < 0x100 → done 2 cycles after the last beat; max_class=19, max_score=0x500, second_score = largest other value.
- Tie: classes 3 and 27 both 0x7FFF_FFFF, all others 0 → max_class=3, second_score=0x7FFF_FFFF.
- SIGNED=1; all scores negative, class 10 = -1 (0xFFFF_FFFF), class 0 = 0x8000_0000 → max_class=10, max_score=0xFFFF_FFFF. Rerun the same stimulus with SIGNED=0 → max_class=0 is wrong; the winner is 10 with 0xFFFF_FFFF unsigned, and second_score=0xFFFF_FFFE if present.
- NUM_CLASSES=20, LANES=8: final-round padding lanes 20–23 = 0xFFFF_FFFF, real classes ≤ 0x10 with class 12 = 0x10 → max_class=12, done after the 3rd beat.
- in_valid toggling every other cycle, then abort after beat 2, then start and a full clean run → no done pulse for the aborted run; outputs keep the previous values until the clean run's done.
- gbdt_rst_n pulsed low while in DRAIN → all outputs 0 and busy=0 immediately; a subsequent start and a full run complete normally.
